// File: rtl/capture_controller_pkg.sv
// Shared types and constants for the capture sequencer: FSM state encoding,
// counter width and the fwd/bwd field positions inside config_data.
package capture_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_DELAY,
      ST_READ,
      ST_READWAIT
   } state_e;

   localparam int CNT_W   = 18;
   localparam int SIZE_W  = 16;
   localparam int FWD_MSB = 31;
   localparam int FWD_LSB = 16;
   localparam int BWD_MSB = 15;
   localparam int BWD_LSB = 0;

   // One bit above CNT_W so the read-back terminal count {bwd,2'b11}+1
   // stays representable when bwd is 16'hFFFF.
   typedef logic [CNT_W:0] cnt_t;

   localparam cnt_t CNT_ONE = cnt_t'(1);

   function automatic cnt_t quad_last(input logic [SIZE_W-1:0] n);
      return {1'b0, n, 2'b11};
   endfunction

endpackage

// File: rtl/capture_controller.sv
// Capture sequencer: pre-trigger streaming, post-trigger fill, then read-back.
// Optional abort/re-arm from any state when CAPTURE_CTRL_REARM_EN is defined.
module capture_controller
   import capture_controller_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        wrSize,
   input  logic [31:0] config_data,
   input  logic        validIn,
   input  logic [31:0] dataIn,
   input  logic        arm,
   input  logic        busy,
   output logic        send,
   output logic [31:0] memoryWrData,
   output logic        memoryRead,
   output logic        memoryWrite,
   output logic        memoryLastWrite
);

   state_e              state_q, state_d;
   cnt_t                cnt_q, cnt_d;
   logic [SIZE_W-1:0]   fwd_q, fwd_d;
   logic [SIZE_W-1:0]   bwd_q, bwd_d;
   logic                send_q, send_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                last_q, last_d;
   logic [31:0]         wr_data_q, wr_data_d;

   cnt_t                fwd_term;
   cnt_t                bwd_term;

   assign fwd_term = quad_last(fwd_q);
   assign bwd_term = quad_last(bwd_q) + CNT_ONE;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fwd_d     = fwd_q;
      bwd_d     = bwd_q;
      send_d    = 1'b0;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      last_d    = 1'b0;
      wr_data_d = wr_data_q;

      if (wrSize) begin
         fwd_d = config_data[FWD_MSB:FWD_LSB];
         bwd_d = config_data[BWD_MSB:BWD_LSB];
      end

      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
            end
         end
         ST_SAMPLE: begin
            if (validIn) begin
               wr_d      = 1'b1;
               wr_data_d = dataIn;
            end
            if (run) state_d = ST_DELAY;
         end
         ST_DELAY: begin
            if (validIn) begin
               wr_d      = 1'b1;
               wr_data_d = dataIn;
               if (cnt_q == fwd_term) begin
                  last_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_READ;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_READ: begin
            if (cnt_q == bwd_term) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               rd_d    = 1'b1;
               send_d  = 1'b1;
               cnt_d   = cnt_q + CNT_ONE;
               state_d = ST_READWAIT;
            end
         end
         // Waiting on send_q too guarantees two cycles between sends even
         // when the transmitter raises busy a cycle late.
         ST_READWAIT: begin
            if (!busy && !send_q) state_d = ST_READ;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef CAPTURE_CTRL_REARM_EN
      if (arm) begin
         state_d   = ST_SAMPLE;
         cnt_d     = '0;
         send_d    = 1'b0;
         rd_d      = 1'b0;
         wr_d      = 1'b0;
         last_d    = 1'b0;
         wr_data_d = '0;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         fwd_q     <= '0;
         bwd_q     <= '0;
         send_q    <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         last_q    <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fwd_q     <= fwd_d;
         bwd_q     <= bwd_d;
         send_q    <= send_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         last_q    <= last_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign send            = send_q;
   assign memoryRead      = rd_q;
   assign memoryWrite     = wr_q;
   assign memoryLastWrite = last_q;
   assign memoryWrData    = wr_data_q;

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: directed scenarios plus random traffic,
// compared every cycle against a count-based transaction model.
module tb_capture_controller;

   logic        clock = 1'b0;
   logic        reset, run, wrSize, validIn, arm, busy;
   logic [31:0] config_data, dataIn;
   logic        send, memoryRead, memoryWrite, memoryLastWrite;
   logic [31:0] memoryWrData;

   capture_controller dut (
      .clock           (clock),
      .reset           (reset),
      .run             (run),
      .wrSize          (wrSize),
      .config_data     (config_data),
      .validIn         (validIn),
      .dataIn          (dataIn),
      .arm             (arm),
      .busy            (busy),
      .send            (send),
      .memoryWrData    (memoryWrData),
      .memoryRead      (memoryRead),
      .memoryWrite     (memoryWrite),
      .memoryLastWrite (memoryLastWrite)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // model: phase 0 idle, 1 pre-trigger, 2 post-trigger, 3 read issue, 4 read wait
   int          m_phase = 0;
   int          m_post_left = 0;
   int          m_rd_left = 0;
   int          m_fwd = 0;
   int          m_bwd = 0;
   logic        e_send = 1'b0, e_rd = 1'b0, e_wr = 1'b0, e_last = 1'b0;
   logic [31:0] e_data = '0;

   int          cyc = 0;
   int          wr_cnt, last_cnt, last_at, send_cnt, min_gap, last_send_cyc, sends_busy;
   logic [31:0] sampled_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_mon();
      wr_cnt = 0; last_cnt = 0; last_at = 0; send_cnt = 0;
      min_gap = 1000; last_send_cyc = -1; sends_busy = 0;
   endtask

   task automatic idle_inputs();
      run = 1'b0; wrSize = 1'b0; validIn = 1'b0; arm = 1'b0; busy = 1'b0;
   endtask

   task automatic model_update();
      logic prev_send;
      prev_send = e_send;
      if (reset) begin
         m_phase = 0; m_post_left = 0; m_rd_left = 0; m_fwd = 0; m_bwd = 0;
         e_send = 0; e_rd = 0; e_wr = 0; e_last = 0; e_data = '0;
      end else begin
         e_send = 0; e_rd = 0; e_wr = 0; e_last = 0;
         if (wrSize) begin
            m_fwd = int'(config_data[31:16]);
            m_bwd = int'(config_data[15:0]);
         end
         case (m_phase)
            0: if (arm) m_phase = 1;
            1: begin
               if (validIn) begin e_wr = 1; e_data = dataIn; end
               if (run) begin m_phase = 2; m_post_left = 4 * m_fwd + 4; end
            end
            2: if (validIn) begin
               e_wr = 1; e_data = dataIn;
               m_post_left--;
               if (m_post_left == 0) begin
                  e_last = 1; m_phase = 3; m_rd_left = 4 * m_bwd + 4;
               end
            end
            3: if (m_rd_left == 0) m_phase = 0;
               else begin e_send = 1; e_rd = 1; m_rd_left--; m_phase = 4; end
            4: if (!busy && !prev_send) m_phase = 3;
            default: m_phase = 0;
         endcase
`ifdef CAPTURE_CTRL_REARM_EN
         if (arm) begin
            m_phase = 1;
            e_send = 0; e_rd = 0; e_wr = 0; e_last = 0; e_data = '0;
         end
`endif
      end
   endtask

   task automatic step();
      @(posedge clock);
      sampled_data = dataIn;
      model_update();
      #1;
      check("send", {31'b0, send}, {31'b0, e_send});
      check("memoryRead", {31'b0, memoryRead}, {31'b0, e_rd});
      check("memoryWrite", {31'b0, memoryWrite}, {31'b0, e_wr});
      check("memoryLastWrite", {31'b0, memoryLastWrite}, {31'b0, e_last});
      check("memoryWrData", memoryWrData, e_data);
      if (memoryWrite) check("wr_data_latency", memoryWrData, sampled_data);
      if (memoryWrite) wr_cnt++;
      if (memoryLastWrite) begin last_cnt++; last_at = wr_cnt; end
      if (send) begin
         if (last_send_cyc >= 0 && (cyc - last_send_cyc) < min_gap) min_gap = cyc - last_send_cyc;
         last_send_cyc = cyc;
         send_cnt++;
         if (busy) sends_busy++;
      end
      cyc++;
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while (m_phase != 0 && n < budget) begin step(); n++; end
      check("idle_reached", {31'b0, m_phase == 0}, 32'd1);
      step();
   endtask

   task automatic wait_sends(input int target, input int budget);
      int n;
      n = 0;
      while (send_cnt < target && n < budget) begin step(); n++; end
      check("send_wait", {31'b0, send_cnt >= target}, 32'd1);
   endtask

   task automatic configure(input logic [31:0] cfg);
      config_data = cfg; wrSize = 1'b1; step(); wrSize = 1'b0;
   endtask

   task automatic arm_pulse();
      arm = 1'b1; step(); arm = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1; idle_inputs(); config_data = '0; dataIn = '0;
      clear_mon();
      repeat (3) step();
      reset = 1'b0;
      step();

      // fwd=1, bwd=0: 5 pre + 8 post writes, last flagged, 4 reads
      configure(32'h0001_0000);
      arm_pulse();
      clear_mon();
      for (int i = 0; i < 5; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0; run = 1'b1; step(); run = 1'b0;
      for (int i = 0; i < 8; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0;
      run_until_idle(200);
      check("a_writes", 32'(wr_cnt), 32'd13);
      check("a_last_at", 32'(last_at), 32'd13);
      check("a_last_cnt", 32'(last_cnt), 32'd1);
      check("a_sends", 32'(send_cnt), 32'd4);

      // fwd=0, bwd=2: run with validIn still writes; 12 sends, spaced >= 2
      configure(32'h0000_0002);
      arm_pulse();
      clear_mon();
      for (int i = 0; i < 3; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      run = 1'b1; validIn = 1'b1; dataIn = $urandom; step(); run = 1'b0;
      for (int i = 0; i < 4; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0;
      run_until_idle(300);
      check("b_writes", 32'(wr_cnt), 32'd8);
      check("b_sends", 32'(send_cnt), 32'd12);
      check("b_min_gap_ge2", {31'b0, min_gap >= 2}, 32'd1);

      // busy held high for 10 cycles after the first send
      configure(32'h0000_0001);
      arm_pulse();
      run = 1'b1; step(); run = 1'b0;
      for (int i = 0; i < 4; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0;
      clear_mon();
      wait_sends(1, 20);
      busy = 1'b1;
      repeat (10) step();
      check("c_no_send_busy", 32'(sends_busy), 32'd0);
      check("c_sends_during_busy", 32'(send_cnt), 32'd1);
      busy = 1'b0;
      n = 0;
      while (send_cnt < 2 && n < 6) begin step(); n++; end
      check("c_resume_le2", {31'b0, send_cnt == 2 && n <= 2}, 32'd1);
      run_until_idle(200);
      check("c_sends_total", 32'(send_cnt), 32'd8);

      // fwd=0 with validIn on alternate cycles in the post-trigger phase
      configure(32'h0000_0000);
      arm_pulse();
      run = 1'b1; step(); run = 1'b0;
      clear_mon();
      for (int i = 0; i < 10; i++) begin
         validIn = (i % 2 == 0); dataIn = $urandom; step();
      end
      validIn = 1'b0;
      check("d_writes", 32'(wr_cnt), 32'd4);
      check("d_last_at", 32'(last_at), 32'd4);
      run_until_idle(200);
      check("d_sends", 32'(send_cnt), 32'd4);

      // reset in the middle of the post-trigger phase
      configure(32'h0003_0003);
      arm_pulse();
      run = 1'b1; step(); run = 1'b0;
      for (int i = 0; i < 3; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      reset = 1'b1; validIn = 1'b1; arm = 1'b1; wrSize = 1'b1; config_data = 32'h0005_0005; step();
      reset = 1'b0; arm = 1'b0; wrSize = 1'b0;
      check("e_rst_send", {31'b0, send}, 32'd0);
      check("e_rst_wr", {31'b0, memoryWrite}, 32'd0);
      check("e_rst_data", memoryWrData, 32'd0);
      clear_mon();
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      run = 1'b0; validIn = 1'b0;
      check("e_idle_no_writes", 32'(wr_cnt), 32'd0);
      // fwd/bwd cleared by reset: 4 post writes, 4 reads
      arm_pulse();
      clear_mon();
      run = 1'b1; step(); run = 1'b0;
      for (int i = 0; i < 6; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0;
      run_until_idle(200);
      check("e_post_writes", 32'(wr_cnt), 32'd4);
      check("e_sends", 32'(send_cnt), 32'd4);

      // arm while reading back
      configure(32'h0000_0003);
      arm_pulse();
      run = 1'b1; step(); run = 1'b0;
      for (int i = 0; i < 4; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0;
      clear_mon();
      wait_sends(2, 20);
      arm_pulse();
`ifdef CAPTURE_CTRL_REARM_EN
      n = send_cnt;
      repeat (30) step();
      check("f_sends_stopped", 32'(send_cnt), 32'(n));
      run = 1'b1; step(); run = 1'b0;
      for (int i = 0; i < 4; i++) begin validIn = 1'b1; dataIn = $urandom; step(); end
      validIn = 1'b0;
      run_until_idle(200);
`else
      run_until_idle(300);
      check("f_sends_complete", 32'(send_cnt), 32'd16);
`endif

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         reset   = ($urandom_range(0, 299) == 0);
         arm     = ($urandom_range(0, 39) == 0);
         run     = ($urandom_range(0, 15) == 0);
         validIn = ($urandom_range(0, 2) != 0);
         busy    = ($urandom_range(0, 3) == 0);
         dataIn  = $urandom;
         wrSize  = (m_phase == 0) && ($urandom_range(0, 5) == 0);
         config_data = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
         step();
      end
      idle_inputs();
      reset = 1'b1; step(); reset = 1'b0; step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
